// File: rtl/usc_rv_pkg.sv
// Shared definitions for the RV32M multi-cycle unit: op encoding, divide timing and
// result widths used by the issue-stage forwarding network.
package usc_rv_pkg;

    typedef enum logic [2:0] {
        McMul    = 3'b000,
        McMulh   = 3'b001,
        McMulhsu = 3'b010,
        McMulhu  = 3'b011,
        McDiv    = 3'b100,
        McDivu   = 3'b101,
        McRem    = 3'b110,
        McRemu   = 3'b111
    } mc_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StIter,
        StFix
    } mc_div_st_e;

    localparam int unsigned USC_RV_MC_DIV_CYCLES = 32;
    localparam int unsigned USC_RV_MC_CNT_W      = $clog2(USC_RV_MC_DIV_CYCLES);
    localparam int unsigned USC_RV_XLEN          = 32;
    localparam int unsigned USC_RV_RES_W         = 64;

endpackage

// File: rtl/usc_rv_mc_div.sv
// Iterative radix-2 restoring divider with sign fixup and a registered result.
// Start is only honoured in idle; flush or reset abandons any divide in progress.
module usc_rv_mc_div
    import usc_rv_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_start,
    input  logic                   i_flush,
    input  logic                   i_signed,
    input  logic                   i_rem,
    input  logic [4:0]             i_rd,
    input  logic [USC_RV_XLEN-1:0] i_src0,
    input  logic [USC_RV_XLEN-1:0] i_src1,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [4:0]             o_rd,
    output logic [USC_RV_XLEN-1:0] o_res
);

    localparam logic [USC_RV_MC_CNT_W-1:0] CntLast =
        USC_RV_MC_CNT_W'(USC_RV_MC_DIV_CYCLES - 1);

    mc_div_st_e                 r_state, w_state_d;
    logic [USC_RV_MC_CNT_W-1:0] r_cnt;
    logic [31:0]                r_quo, r_rem, r_dvs, r_res;
    logic                       r_q_neg, r_r_neg, r_sel_rem, r_done;
    logic [4:0]                 r_rd;

    logic        w_div_zero, w_ovf;
    logic [31:0] w_dvd_abs, w_dvs_abs;
    logic [32:0] w_rem_sh, w_diff;
    logic        w_qbit;
    logic [31:0] w_rem_nx, w_quo_fix, w_rem_fix;

    assign w_div_zero = (i_src1 == 32'd0);
    assign w_ovf      = i_signed && (i_src0 == 32'h8000_0000) && (i_src1 == 32'hFFFF_FFFF);
    assign w_dvd_abs  = (i_signed && i_src0[31]) ? (32'd0 - i_src0) : i_src0;
    assign w_dvs_abs  = (i_signed && i_src1[31]) ? (32'd0 - i_src1) : i_src1;

    // Dividend bits shift out of the top of r_quo as quotient bits shift in.
    assign w_rem_sh  = {r_rem, r_quo[31]};
    assign w_diff    = w_rem_sh - {1'b0, r_dvs};
    assign w_qbit    = ~w_diff[32];
    assign w_rem_nx  = w_qbit ? w_diff[31:0] : w_rem_sh[31:0];
    assign w_quo_fix = r_q_neg ? (32'd0 - r_quo) : r_quo;
    assign w_rem_fix = r_r_neg ? (32'd0 - r_rem) : r_rem;

    always_ff @(posedge clk) begin
        if (!reset_n || i_flush) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_d = (w_div_zero || w_ovf) ? StFix : StIter;
                end
            end
            StIter: begin
                if (r_cnt == CntLast) begin
                    w_state_d = StFix;
                end
            end
            StFix:   w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt     <= '0;
            r_quo     <= '0;
            r_rem     <= '0;
            r_dvs     <= '0;
            r_q_neg   <= 1'b0;
            r_r_neg   <= 1'b0;
            r_sel_rem <= 1'b0;
            r_rd      <= '0;
            r_res     <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (!i_flush) begin
                case (r_state)
                    StIdle: begin
                        if (i_start) begin
                            r_rd      <= i_rd;
                            r_sel_rem <= i_rem;
                            r_cnt     <= '0;
                            r_dvs     <= w_dvs_abs;
                            if (w_div_zero) begin
                                r_quo   <= 32'hFFFF_FFFF;
                                r_rem   <= i_src0;
                                r_q_neg <= 1'b0;
                                r_r_neg <= 1'b0;
                            end else if (w_ovf) begin
                                r_quo   <= 32'h8000_0000;
                                r_rem   <= 32'd0;
                                r_q_neg <= 1'b0;
                                r_r_neg <= 1'b0;
                            end else begin
                                r_quo   <= w_dvd_abs;
                                r_rem   <= 32'd0;
                                r_q_neg <= i_signed && (i_src0[31] ^ i_src1[31]);
                                r_r_neg <= i_signed && i_src0[31];
                            end
                        end
                    end
                    StIter: begin
                        r_quo <= {r_quo[30:0], w_qbit};
                        r_rem <= w_rem_nx;
                        r_cnt <= r_cnt + USC_RV_MC_CNT_W'(1);
                    end
                    StFix: begin
                        r_res  <= r_sel_rem ? w_rem_fix : w_quo_fix;
                        r_done <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_busy = (r_state != StIdle);
    assign o_done = r_done;
    assign o_rd   = r_rd;
    assign o_res  = r_res;

endmodule

// File: rtl/usc_rv_mc_unit.sv
// RV32M multi-cycle unit: two-stage multiply pipe plus the iterative divider, merged onto a
// single registered result port. Divides hold off issue through mc_busy.
module usc_rv_mc_unit
    import usc_rv_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    mc_op_vld_i,
    input  logic [2:0]              mc_op_ctl_i,
    input  logic [4:0]              mc_op_rd_i,
    input  logic [USC_RV_XLEN-1:0]  mc_op_src0_i,
    input  logic [USC_RV_XLEN-1:0]  mc_op_src1_i,
    input  logic                    mc_flush_i,
    output logic                    mc_busy,
    output logic                    mc_res_vld,
    output logic [4:0]              mc_res_rd,
    output logic [USC_RV_RES_W-1:0] mc_res_data,
    output logic                    mc_div_done
);

    mc_op_e      w_op;
    logic        w_accept, w_mul_acc, w_div_start;
    logic        w_a_sgn, w_b_sgn;
    logic [63:0] w_prod;
    logic [31:0] w_mul_res;

    logic        w_div_busy, w_div_done;
    logic [4:0]  w_div_rd;
    logic [31:0] w_div_res;

    logic        r_m_vld, r_m_hi;
    logic [4:0]  r_m_rd;
    logic [32:0] r_m_a, r_m_b;
    logic        r_p_vld;
    logic [4:0]  r_p_rd;
    logic [31:0] r_p_data;

    assign w_op        = mc_op_e'(mc_op_ctl_i);
    assign w_accept    = mc_op_vld_i && !w_div_busy && !mc_flush_i;
    assign w_mul_acc   = w_accept && !mc_op_ctl_i[2];
    assign w_div_start = w_accept && mc_op_ctl_i[2];
    assign w_a_sgn     = (w_op == McMulh) || (w_op == McMulhsu);
    assign w_b_sgn     = (w_op == McMulh);

    // 33-bit operands sign-extended to 64 give the exact low 64 product bits for all forms.
    assign w_prod    = {{31{r_m_a[32]}}, r_m_a} * {{31{r_m_b[32]}}, r_m_b};
    assign w_mul_res = r_m_hi ? w_prod[63:32] : w_prod[31:0];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_m_vld  <= 1'b0;
            r_m_hi   <= 1'b0;
            r_m_rd   <= '0;
            r_m_a    <= '0;
            r_m_b    <= '0;
            r_p_vld  <= 1'b0;
            r_p_rd   <= '0;
            r_p_data <= '0;
        end else begin
            r_m_vld <= w_mul_acc;
            r_p_vld <= r_m_vld && !mc_flush_i;
            if (w_mul_acc) begin
                r_m_hi <= (w_op != McMul);
                r_m_rd <= mc_op_rd_i;
                r_m_a  <= {w_a_sgn && mc_op_src0_i[31], mc_op_src0_i};
                r_m_b  <= {w_b_sgn && mc_op_src1_i[31], mc_op_src1_i};
            end
            if (r_m_vld && !mc_flush_i) begin
                r_p_rd   <= r_m_rd;
                r_p_data <= w_mul_res;
            end
        end
    end

    usc_rv_mc_div u_div (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_start  (w_div_start),
        .i_flush  (mc_flush_i),
        .i_signed (!mc_op_ctl_i[0]),
        .i_rem    (mc_op_ctl_i[1]),
        .i_rd     (mc_op_rd_i),
        .i_src0   (mc_op_src0_i),
        .i_src1   (mc_op_src1_i),
        .o_busy   (w_div_busy),
        .o_done   (w_div_done),
        .o_rd     (w_div_rd),
        .o_res    (w_div_res)
    );

    // Issue blocking guarantees the two sources never complete in the same cycle.
    assign mc_busy     = w_div_busy;
    assign mc_res_vld  = r_p_vld || w_div_done;
    assign mc_res_rd   = w_div_done ? w_div_rd : r_p_rd;
    assign mc_res_data = {32'd0, (w_div_done ? w_div_res : r_p_data)};
    assign mc_div_done = w_div_done;

endmodule

// File: doc/usc_rv_mc_unit.md
# usc_rv_mc_unit

Multi-cycle execution unit for the RV32M multiply/divide instructions. It receives ops from the issue stage over the `mc_op_*` port group and returns 32-bit results tagged with the destination register. The `mc_res_data` / `mc_div_done` outputs feed the issue stage's writeback and forwarding network. Multiplies are pipelined at two cycles. Divides are iterative, radix-2, and block further issue while active.

## Interface
- Reset: one clock; reset is synchronous and active-low.
- No parameters. Op encoding comes from `usc_rv_pkg`.

Ports:
- `clk` in 1: core clock.
- `reset_n` in 1: synchronous active-low reset.
- `mc_op_vld_i` in 1: op valid from issue.
- `mc_op_ctl_i` in 3: RV M funct3.
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `mc_op_rd_i` in 5: destination register tag.
- `mc_op_src0_i` in 32: rs1 (multiplicand / dividend).
- `mc_op_src1_i` in 32: rs2 (multiplier / divisor).
- `mc_flush_i` in 1: kill all in-flight ops.
- `mc_busy` out 1: divide in progress; issue must not send ops.
- `mc_res_vld` out 1: result valid, one-cycle pulse per op.
- `mc_res_rd` out 5: tag of the completing op.
- `mc_res_data` out 64: [31:0] result, [63:32] zero.
- `mc_div_done` out 1: equals `mc_res_vld` for DIV/DIVU/REM/REMU, else 0.

## Operation
- Accept: an op is accepted when `mc_op_vld_i & ~mc_busy & ~mc_flush_i`.
  - `mc_op_vld_i` while `mc_busy`=1 is illegal. The RTL ignores it; the bench flags it with an assertion.
- MUL path (2-stage pipe):
  - Stage 1 registers operands, extended to 33 bits: signed for MULH / MULHSU-src0, otherwise zero.
  - Stage 2 forms the 66-bit product and registers low or high 32 bits per op.
  - A new multiply may be accepted every cycle.
- DIV FSM states: IDLE, ITER, FIX.
  - IDLE → ITER on a normal divide accept. Load |src0|, |src1| (absolute only for signed ops), record quotient/remainder sign, clear counter.
  - IDLE → FIX directly on a special case:
    - divisor = 0: quotient = FFFFFFFF, remainder = dividend.
    - signed with dividend 80000000 and divisor FFFFFFFF: quotient = 80000000, remainder = 0.
  - ITER: one restoring step per cycle. 32 cycles, 5-bit counter, → FIX when the counter wraps from 31.
  - FIX: apply signs (quotient negative iff operand signs differ and divisor ≠ 0; remainder takes the dividend sign), select quotient or remainder, register the result, → IDLE.
- `mc_busy` = (state ≠ IDLE).
- Flush: on `mc_flush_i` the FSM → IDLE and mul stage valids clear on the same edge. No `mc_res_vld` is produced for killed ops. An op presented in the flush cycle is dropped.
- Reset: FSM IDLE, pipe valids 0, all outputs 0.
  - Reset mid-divide behaves as flush.
  - The first op may be accepted the cycle after `reset_n` rises.

## Timing
Times are relative to accept cycle T.
- MUL: result at T+2. Back-to-back muls give back-to-back results.
- Normal divide:
  - `mc_busy` high T+1..T+33.
  - ITER T+1..T+32, FIX T+33.
  - `mc_res_vld` / `mc_div_done` at T+34.
- Special-case divide:
  - FIX at T+1, `mc_busy` high T+1 only.
  - Result at T+2, so no collision with a mul accepted at T−1.
- Issue may accept a new op in the cycle the divide result is valid, i.e. when `mc_busy` is low.
- A mul accepted at T−1 completes at T+1 while a divide accepted at T runs. The result port never sees two results in one cycle.
- All outputs are registered. There is no combinational path from inputs to outputs except `mc_busy`, which is a state decode only.

## Structure
- `usc_rv_pkg` holds:
  - the 3-bit mc op enum (funct3 values above);
  - `USC_RV_MC_DIV_CYCLES` = 32;
  - result-width constants shared with issue forwarding.
- Sub-module `usc_rv_mc_div` holds the divide FSM, restoring datapath and fixup. It has a start/flush/done handshake and a result register.
- The multiply pipe and the result mux stay in `usc_rv_mc_unit`.

## Test plan
- MUL 7 × FFFFFFFD (−3), rd=5 → `mc_res_vld` at T+2, data 0000_0000_FFFF_FFEB, `mc_res_rd`=5, `mc_div_done`=0.
- MULHU FFFFFFFF×FFFFFFFF → FFFFFFFE. MULH same operands → 00000000. MULHSU FFFFFFFF×FFFFFFFF → FFFFFFFF. All issued back-to-back, results on consecutive cycles T+2..T+4.
- DIV FFFFFFF9 (−7) / 2 → FFFFFFFD at T+34, `mc_div_done`=1, `mc_busy` high T+1..T+33. REM same operands → FFFFFFFF.
- DIVU 5/0 → FFFFFFFF at T+2. REMU 5/0 → 00000005. DIV 80000000/FFFFFFFF → 80000000. REM same → 0.
- DIVU 100/7 accepted at T, `mc_flush_i` at T+10 → no `mc_res_vld` ever. `mc_busy` low at T+11. A MUL accepted at T+11 returns correctly at T+13.
- MUL at T−1 plus DIV 9/3 at T → mul result at T+1, quotient 3 at T+34. Also `reset_n` low at T+5 of a divide → all outputs 0, no result.
